// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-lane data memory.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN adds the CLEAR state.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01
`ifdef DMEM_CLEAR_ON_RESET_EN
        , S_CLEAR = 2'b10
`endif
    } state_e;

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between the datapath and the data memory.
interface dmem_bytelane_if;

    logic [dmem_pkg::WORD_W-1:0] Address;
    logic                        MemRead;
    logic                        MemWrite;
    logic [1:0]                  Size;
    logic                        LoadUnsigned;
    logic [dmem_pkg::WORD_W-1:0] WriteData;
    logic                        Ready;
    logic [dmem_pkg::WORD_W-1:0] ReadData;
    logic                        ReadValid;
    logic                        AddrError;

    modport master (
        output Address, MemRead, MemWrite, Size, LoadUnsigned, WriteData,
        input  Ready, ReadData, ReadValid, AddrError
    );

    modport slave (
        input  Address, MemRead, MemWrite, Size, LoadUnsigned, WriteData,
        output Ready, ReadData, ReadValid, AddrError
    );

endinterface

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed byte/half out of a 32-bit word,
// right-justifies it and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic [WORD_W-1:0] result
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    // Lane select followed by extension according to access size
    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        result = '0;
        case (size)
            SZ_BYTE: begin
                if (load_unsigned) result = {24'h0, lane_b};
                else               result = WORD_W'(lane_b);
            end
            SZ_HALF: begin
                if (load_unsigned) result = {16'h0, lane_h};
                else               result = WORD_W'(lane_h);
            end
            SZ_WORD: result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with byte/half/word access, load extension,
// Ready/ReadValid handshake and WAIT_STATES busy cycles per access.
// Stores commit on the acceptance edge; loads sample the array on the edge
// that ends the access. Illegal accesses pulse AddrError and touch nothing.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN zeroes the array after reset.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    dmem_bytelane_if.slave  bus
);

    localparam int IDX = $clog2(DEPTH);

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam state_e RESET_STATE = S_CLEAR;
`else
    localparam state_e RESET_STATE = S_IDLE;
`endif

    logic [WORD_W-1:0] mem [DEPTH];

    state_e            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              ready, req, accept, fire;

    logic              req_err;
    logic [IDX-1:0]    req_idx;
    logic [3:0]        be;
    logic [WORD_W-1:0] wlanes;
    logic              store_we;

    logic [IDX-1:0]    idx_p0;
    logic [1:0]        off_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic              rd_p0;
    logic              err_p0;

    logic [IDX-1:0]    rsp_idx;
    logic [1:0]        rsp_off;
    logic [1:0]        rsp_size;
    logic              rsp_uns;
    logic              rsp_rd;
    logic              rsp_err;
    logic [WORD_W-1:0] rsp_word;
    logic [WORD_W-1:0] rsp_data;

    logic [WORD_W-1:0] data_p1;
    logic              vld_p1;
    logic              err_p1;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [IDX-1:0]    clr_idx, clr_next;
    logic              clr_we;
`endif

    function automatic logic access_error(input logic [WORD_W-1:0] addr,
                                          input logic [1:0]        size,
                                          input logic              rd,
                                          input logic              wr);
        logic bad;
        bad = rd && wr;
        if (size == 2'b11)                        bad = 1'b1;
        if (size == SZ_HALF && addr[0])           bad = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
        if (addr[WORD_W-1:IDX+2] != '0)           bad = 1'b1;
        return bad;
    endfunction

    assign req      = bus.MemRead | bus.MemWrite;
    assign req_idx  = bus.Address[IDX+1:2];
    assign req_err  = access_error(bus.Address, bus.Size, bus.MemRead, bus.MemWrite);
    assign store_we = accept && bus.MemWrite && !req_err;

    // Next-state, counter and handshake decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        accept     = 1'b0;
        fire       = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        clr_next   = clr_idx;
        clr_we     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                ready = !rst;
                if (ready && req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        fire = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    fire       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
`ifdef DMEM_CLEAR_ON_RESET_EN
            S_CLEAR: begin
                clr_we   = 1'b1;
                clr_next = clr_idx + 1'b1;
                if (clr_idx == IDX'(DEPTH - 1)) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // State register, wait counter and clear pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET_STATE;
            cnt     <= '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_idx <= '0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_idx <= clr_next;
`endif
        end
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        be     = 4'b0000;
        wlanes = bus.WriteData;
        case (bus.Size)
            SZ_BYTE: begin
                be     = 4'b0001 << bus.Address[1:0];
                wlanes = {4{bus.WriteData[7:0]}};
            end
            SZ_HALF: begin
                be     = bus.Address[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{bus.WriteData[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array writes: committed stores and the post-reset clear sweep
    always_ff @(posedge clk) begin
        if (store_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[req_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (clr_we) mem[clr_idx] <= '0;
`endif
    end

    // Stage p0: request captured at acceptance for multi-cycle accesses
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0  <= req_idx;
            off_p0  <= bus.Address[1:0];
            size_p0 <= bus.Size;
            uns_p0  <= bus.LoadUnsigned;
            rd_p0   <= bus.MemRead;
            err_p0  <= req_err;
        end
    end

    // Response source: live inputs for zero-wait accesses, else the p0 copy
    always_comb begin
        if (state == S_WAIT) begin
            rsp_idx  = idx_p0;
            rsp_off  = off_p0;
            rsp_size = size_p0;
            rsp_uns  = uns_p0;
            rsp_rd   = rd_p0;
            rsp_err  = err_p0;
        end else begin
            rsp_idx  = req_idx;
            rsp_off  = bus.Address[1:0];
            rsp_size = bus.Size;
            rsp_uns  = bus.LoadUnsigned;
            rsp_rd   = bus.MemRead;
            rsp_err  = req_err;
        end
    end

    assign rsp_word = mem[rsp_idx];

    dmem_load_align u_align (
        .word          (rsp_word),
        .offset        (rsp_off),
        .size          (rsp_size),
        .load_unsigned (rsp_uns),
        .result        (rsp_data)
    );

    // Stage p1: registered response; ReadData holds between read responses
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= fire && rsp_rd;
            err_p1 <= fire && rsp_err;
            if (fire && rsp_rd) data_p1 <= rsp_err ? '0 : rsp_data;
        end
    end

    assign bus.Ready     = ready;
    assign bus.ReadData  = data_p1;
    assign bus.ReadValid = vld_p1;
    assign bus.AddrError = err_p1;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane: one zero-wait instance and one with
// three wait states, plus a DEPTH=16 instance when DMEM_CLEAR_ON_RESET_EN
// is defined.
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_bytelane_if b0();
    dmem_bytelane_if b3();

    dmem_bytelane #(.DEPTH(256), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    dmem_bytelane #(.DEPTH(256), .WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

`ifdef DMEM_CLEAR_ON_RESET_EN
    dmem_bytelane_if b16();
    dmem_bytelane #(.DEPTH(16), .WAIT_STATES(0)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc0(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        b0.MemRead = rd; b0.MemWrite = wr; b0.Address = addr;
        b0.Size = sz; b0.LoadUnsigned = uns; b0.WriteData = wd;
        tick();
        b0.MemRead = 1'b0; b0.MemWrite = 1'b0;
    endtask

    task automatic acc3(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        b3.MemRead = rd; b3.MemWrite = wr; b3.Address = addr;
        b3.Size = sz; b3.LoadUnsigned = uns; b3.WriteData = wd;
        tick();
        b3.MemRead = 1'b0; b3.MemWrite = 1'b0;
    endtask

`ifdef DMEM_CLEAR_ON_RESET_EN
    task automatic acc16(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic [31:0] wd);
        b16.MemRead = rd; b16.MemWrite = wr; b16.Address = addr;
        b16.Size = sz; b16.LoadUnsigned = 1'b0; b16.WriteData = wd;
        tick();
        b16.MemRead = 1'b0; b16.MemWrite = 1'b0;
    endtask
`endif

    function automatic logic all_ready();
        logic r;
        r = b0.Ready & b3.Ready;
`ifdef DMEM_CLEAR_ON_RESET_EN
        r = r & b16.Ready;
`endif
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!all_ready() && n < 2000) begin
            tick();
            n++;
        end
        chk1(tag, all_ready(), 1'b1);
    endtask

    logic [31:0] b2b_data [3];
    logic [31:0] post_rst_exp;
    int          n_clr;

    initial begin
        b2b_data[0] = 32'hA5A5_5A5A;
        b2b_data[1] = 32'h0000_0001;
        b2b_data[2] = 32'hFFFF_0000;
`ifdef DMEM_CLEAR_ON_RESET_EN
        post_rst_exp = 32'h0;
`else
        post_rst_exp = 32'hCAFE_BABE;
`endif
        n_clr = 0;

        b0.MemRead = 0; b0.MemWrite = 0; b0.Address = 0; b0.Size = 0; b0.LoadUnsigned = 0; b0.WriteData = 0;
        b3.MemRead = 0; b3.MemWrite = 0; b3.Address = 0; b3.Size = 0; b3.LoadUnsigned = 0; b3.WriteData = 0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        b16.MemRead = 0; b16.MemWrite = 0; b16.Address = 0; b16.Size = 0; b16.LoadUnsigned = 0; b16.WriteData = 0;
`endif

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk1("rst_ready0", b0.Ready, 1'b0);
        chk1("rst_rv0", b0.ReadValid, 1'b0);
        chk1("rst_ae0", b0.AddrError, 1'b0);
        chk("rst_rd0", b0.ReadData, 32'h0);
        chk1("rst_ready3", b3.Ready, 1'b0);
        rst = 1'b0;
        wait_ready("ready_after_rst");

        // Store then load back with every extension
        acc0(0, 1, 32'h10, SZ_WORD, 0, 32'h8000_00F0);
        chk1("sw_ae", b0.AddrError, 1'b0);
        chk1("sw_rv", b0.ReadValid, 1'b0);
        acc0(1, 0, 32'h10, SZ_BYTE, 0, 0);
        chk1("lb_rv", b0.ReadValid, 1'b1);
        chk("lb", b0.ReadData, 32'hFFFF_FFF0);
        acc0(1, 0, 32'h10, SZ_BYTE, 1, 0);
        chk("lbu", b0.ReadData, 32'h0000_00F0);
        acc0(1, 0, 32'h12, SZ_HALF, 0, 0);
        chk("lh", b0.ReadData, 32'hFFFF_8000);
        acc0(1, 0, 32'h10, SZ_WORD, 0, 0);
        chk("lw", b0.ReadData, 32'h8000_00F0);
        tick();
        chk1("rv_pulse", b0.ReadValid, 1'b0);
        chk("rd_hold", b0.ReadData, 32'h8000_00F0);

        // Partial stores
        acc0(0, 1, 32'h20, SZ_WORD, 0, 32'h1122_3344);
        acc0(0, 1, 32'h21, SZ_BYTE, 0, 32'hDEAD_BEAA);
        chk("rd_hold_st", b0.ReadData, 32'h8000_00F0);
        acc0(1, 0, 32'h20, SZ_WORD, 0, 0);
        chk("sb_merge", b0.ReadData, 32'h1122_AA44);
        acc0(1, 0, 32'h22, SZ_HALF, 1, 0);
        chk("lhu_hi", b0.ReadData, 32'h0000_1122);
        acc0(0, 1, 32'h22, SZ_HALF, 0, 32'h1234_5566);
        acc0(1, 0, 32'h20, SZ_WORD, 0, 0);
        chk("sh_merge", b0.ReadData, 32'h5566_AA44);
        acc0(1, 0, 32'h20, SZ_HALF, 0, 0);
        chk("lh_lo", b0.ReadData, 32'hFFFF_AA44);

        // Rejected accesses
        acc0(1, 0, 32'h22, SZ_WORD, 0, 0);
        chk1("lw_mis_ae", b0.AddrError, 1'b1);
        chk1("lw_mis_rv", b0.ReadValid, 1'b1);
        chk("lw_mis_rd", b0.ReadData, 32'h0);
        tick();
        chk1("ae_pulse", b0.AddrError, 1'b0);
        acc0(0, 1, 32'h23, SZ_HALF, 0, 32'h0000_BEEF);
        chk1("sh_mis_ae", b0.AddrError, 1'b1);
        chk1("sh_mis_rv", b0.ReadValid, 1'b0);
        acc0(1, 0, 32'h20, SZ_WORD, 0, 0);
        chk("sh_mis_keep", b0.ReadData, 32'h5566_AA44);
        acc0(0, 1, 32'h0, SZ_WORD, 0, 32'h0BAD_F00D);
        acc0(0, 1, 32'h400, SZ_WORD, 0, 32'hFFFF_FFFF);
        chk1("oor_ae", b0.AddrError, 1'b1);
        acc0(1, 0, 32'h0, SZ_WORD, 0, 0);
        chk("oor_keep", b0.ReadData, 32'h0BAD_F00D);
        acc0(1, 1, 32'h20, SZ_WORD, 0, 32'h0);
        chk1("rdwr_ae", b0.AddrError, 1'b1);
        acc0(1, 0, 32'h20, SZ_WORD, 0, 0);
        chk("rdwr_keep", b0.ReadData, 32'h5566_AA44);
        acc0(1, 0, 32'h20, 2'b11, 0, 0);
        chk1("size11_ae", b0.AddrError, 1'b1);

        // Back-to-back store/load pairs
        for (int i = 0; i < 3; i++) begin
            acc0(0, 1, 32'h30, SZ_WORD, 0, b2b_data[i]);
            chk1($sformatf("b2b_sw_rv%0d", i), b0.ReadValid, 1'b0);
            acc0(1, 0, 32'h30, SZ_WORD, 0, 0);
            chk1($sformatf("b2b_lw_rv%0d", i), b0.ReadValid, 1'b1);
            chk($sformatf("b2b_lw%0d", i), b0.ReadData, b2b_data[i]);
        end

        // Wait states: store busy window
        acc3(0, 1, 32'h40, SZ_WORD, 0, 32'hCAFE_BABE);
        chk1("ws_w_t1", b3.Ready, 1'b0);
        tick();
        tick();
        chk1("ws_w_t3", b3.Ready, 1'b0);
        tick();
        chk1("ws_w_t4", b3.Ready, 1'b1);
        chk1("ws_w_rv", b3.ReadValid, 1'b0);

        // Wait states: read with an intruding store held while busy
        b3.MemRead = 1; b3.MemWrite = 0; b3.Address = 32'h40; b3.Size = SZ_WORD; b3.LoadUnsigned = 0;
        tick();
        b3.MemRead = 0; b3.MemWrite = 1; b3.WriteData = 32'hFFFF_FFFF;
        chk1("ws_r_t1_rdy", b3.Ready, 1'b0);
        chk1("ws_r_t1_rv", b3.ReadValid, 1'b0);
        tick();
        chk1("ws_r_t2_rdy", b3.Ready, 1'b0);
        chk1("ws_r_t2_rv", b3.ReadValid, 1'b0);
        tick();
        chk1("ws_r_t3_rdy", b3.Ready, 1'b0);
        chk1("ws_r_t3_rv", b3.ReadValid, 1'b0);
        tick();
        b3.MemWrite = 0;
        chk1("ws_r_t4_rv", b3.ReadValid, 1'b1);
        chk1("ws_r_t4_rdy", b3.Ready, 1'b1);
        chk("ws_r_t4_rd", b3.ReadData, 32'hCAFE_BABE);
        tick();
        chk1("ws_rv_pulse", b3.ReadValid, 1'b0);

        // Wait states: error timing for read and write
        acc3(1, 0, 32'h22, SZ_WORD, 0, 0);
        chk1("ws_err_t1", b3.AddrError, 1'b0);
        tick();
        tick();
        chk1("ws_err_t3", b3.AddrError, 1'b0);
        tick();
        chk1("ws_err_t4", b3.AddrError, 1'b1);
        chk("ws_err_rd", b3.ReadData, 32'h0);
        acc3(0, 1, 32'h400, SZ_WORD, 0, 32'h1);
        tick();
        tick();
        chk1("ws_werr_t3", b3.AddrError, 1'b0);
        tick();
        chk1("ws_werr_t4", b3.AddrError, 1'b1);

        // Intruding store was ignored
        acc3(1, 0, 32'h40, SZ_WORD, 0, 0);
        repeat (3) tick();
        chk("ws_ignored", b3.ReadData, 32'hCAFE_BABE);

`ifdef DMEM_CLEAR_ON_RESET_EN
        acc16(0, 1, 32'h3C, SZ_WORD, 32'h1234_5678);
        acc16(1, 0, 32'h3C, SZ_WORD, 0);
        chk("d16_pre", b16.ReadData, 32'h1234_5678);
`endif

        // Reset in the middle of a wait
        acc3(1, 0, 32'h40, SZ_WORD, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk1("mid_rst_rdy", b3.Ready, 1'b0);
        chk1("mid_rst_rv", b3.ReadValid, 1'b0);
        chk1("mid_rst_ae", b3.AddrError, 1'b0);
        chk("mid_rst_rd3", b3.ReadData, 32'h0);
        chk("mid_rst_rd0", b0.ReadData, 32'h0);
        tick();
        chk1("mid_rst_rv2", b3.ReadValid, 1'b0);
        rst = 1'b0;
        tick();
        chk1("no_rv_after_rst", b3.ReadValid, 1'b0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        n_clr = 1;
        while (!b16.Ready && n_clr < 100) begin
            tick();
            n_clr++;
        end
        chk("clr_cycles", 32'(n_clr), 32'd16);
`endif
        wait_ready("ready_after_rst2");

        acc3(1, 0, 32'h40, SZ_WORD, 0, 0);
        repeat (3) tick();
        chk("post_rst_lw3", b3.ReadData, post_rst_exp);
        acc0(1, 0, 32'h10, SZ_WORD, 0, 0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        chk("post_rst_lw0", b0.ReadData, 32'h0);
        acc16(1, 0, 32'h3C, SZ_WORD, 0);
        chk("d16_clr_hi", b16.ReadData, 32'h0);
        acc16(1, 0, 32'h0, SZ_WORD, 0);
        chk("d16_clr_lo", b16.ReadData, 32'h0);
`else
        chk("post_rst_lw0", b0.ReadData, 32'h8000_00F0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised data memory for the MIPS datapath: byte-addressed, 32-bit data, byte/half/word loads and stores with sign or zero extension, and a Ready/ReadValid handshake with configurable wait states. It sits between the ALU address output and the write-back mux and replaces the single-cycle word-only memory. Misaligned or out-of-range accesses are flagged instead of silently aliasing.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, at least 4
- WAIT_STATES, 0, extra busy cycles per access, 0..15
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- Address  in  32  byte address
- MemRead  in  1  read request
- MemWrite  in  1  write request
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- LoadUnsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- WriteData  in  32  store data, right-justified
- Ready  out  1  block accepts a request this cycle
- ReadData  out  32  formatted load result
- ReadValid  out  1  one-cycle pulse: ReadData is valid
- AddrError  out  1  one-cycle pulse: last access was rejected

## Operation
- Storage: DEPTH x 32 array. Byte lanes are little-endian; byte 0 is bits 7:0. Word index = Address[IDX+1:2], where IDX = $clog2(DEPTH).
- A request is accepted on a posedge where Ready=1 and MemRead or MemWrite is 1. Address, Size, LoadUnsigned and WriteData are latched at acceptance. Inputs are ignored while Ready=0.
- Error conditions (no array access, AddrError pulse):
  - MemRead and MemWrite both 1
  - Size=11
  - half access with Address[0]=1
  - word access with Address[1:0]≠0
  - Address ≥ 4*DEPTH
- Stores commit on the acceptance edge:
  - sb writes WriteData[7:0] to lane Address[1:0]
  - sh writes WriteData[15:0] to lanes {Address[1],0} and {Address[1],1}
  - sw writes all lanes
  - Unselected lanes keep their contents.
- Loads: the array is sampled on the edge that ends the access. The selected byte or half is right-justified, then sign- or zero-extended per LoadUnsigned. A rejected read returns ReadData=0 with ReadValid=1.
- ReadData holds its value until the next read response.
- FSM:
  - CLEAR: only present with the configuration macro.
  - IDLE: Ready=1.
  - WAIT: Ready=0; counter runs from WAIT_STATES-1 down to 0, then returns to IDLE.
  - Acceptance with WAIT_STATES=0 stays in IDLE, giving back-to-back accesses.
- Reset: Ready=0, ReadData=0, ReadValid=0, AddrError=0, counter=0.
  - An access in flight when reset asserts is aborted and gives no ReadValid.
  - A store already committed is kept, unless the array is cleared.

## Timing
- Read latency: ReadValid is high in cycle T+WAIT_STATES+1, where T is the acceptance edge.
- AddrError uses the same timing for both reads and writes.
- Ready is low for exactly WAIT_STATES cycles after each acceptance.
- Throughput: one access per WAIT_STATES+1 cycles.
- A read accepted in the cycle after a store to the same word returns the new data. Read-after-write needs no bypass, because the store commits at its own acceptance edge.

## Configuration
- DMEM_CLEAR_ON_RESET_EN defined:
  - Leaving reset enters CLEAR, which writes 0 to one word per cycle, index 0..DEPTH-1.
  - Ready=0 for DEPTH cycles, then IDLE.
  - Reset asserted during CLEAR restarts the sweep at index 0.
- Undefined:
  - No CLEAR state; the array contents are unspecified after reset.
  - IDLE in the first cycle after rst deasserts.

## Structure
- Package dmem_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state enum
  - constant for the word width (32)
- Sub-module dmem_load_align: combinational lane select plus sign/zero extension, from (word, Address[1:0], Size, LoadUnsigned) to a 32-bit result. Reused by the future cache.

## Test plan
- Store, then load back: sw 0x8000_00F0 at 0x10; lb at 0x10 → 0xFFFF_FFF0; lbu → 0x0000_00F0; lh at 0x12 → 0xFFFF_8000; lw → 0x8000_00F0.
- Partial store: word 0x1122_3344 at 0x20; sb 0xAA at 0x21; then lw → 0x1122_AA44.
- Errors, each giving an AddrError pulse with the array unchanged:
  - lw at 0x22
  - sh at 0x23
  - write at 0x400 with DEPTH=256
  - MemRead=MemWrite=1
- Wait states (WAIT_STATES=3): read accepted at T → Ready low T+1..T+3, ReadValid at T+4. A new request held during T+1..T+3 is ignored.
- Back-to-back (WAIT_STATES=0): alternating sw/lw on consecutive cycles to the same address → each lw returns the preceding store's data one cycle later.
- Reset: rst mid-WAIT → no ReadValid; all outputs 0. With DMEM_CLEAR_ON_RESET_EN and DEPTH=16: Ready rises 16 cycles after rst falls; lw at any address → 0.
